// File: rtl/decode_ctrl_if.sv
// Decode-stage bus: IF/DE instruction fields flow in, the decoded and
// registered DE/EX control bundles and the pipeline hold signals flow out.
// The master drives the instruction fields and flush_i. The slave is the
// decode controller.
interface decode_ctrl_if #(
    parameter int OPCODE_W = 5,
    parameter int COND_W   = 4,
    parameter int REG_W    = 4,
    parameter int EX_W     = 15,
    parameter int MA_W     = 2,
    parameter int WB_W     = 3
) ();
    logic                valid_i;
    logic [OPCODE_W-1:0] opcode_i;
    logic                bit16_i;
    logic [COND_W-1:0]   cond_i;
    logic [REG_W-1:0]    rs1_i;
    logic [REG_W-1:0]    rs2_i;
    logic [REG_W-1:0]    rd_i;
    logic                flush_i;
    logic [1:0]          sign_ext_o;
    logic                rs2_sel_o;
    logic [EX_W-1:0]     ex_o;
    logic [MA_W-1:0]     ma_o;
    logic [WB_W-1:0]     wb_o;
    logic [REG_W-1:0]    rd_o;
    logic                valid_o;
    logic                stall_o;
    logic                halt_o;
    logic                illegal_o;

    modport master (
        output valid_i, opcode_i, bit16_i, cond_i, rs1_i, rs2_i, rd_i, flush_i,
        input  sign_ext_o, rs2_sel_o, ex_o, ma_o, wb_o, rd_o, valid_o,
               stall_o, halt_o, illegal_o
    );

    modport slave (
        input  valid_i, opcode_i, bit16_i, cond_i, rs1_i, rs2_i, rd_i, flush_i,
        output sign_ext_o, rs2_sel_o, ex_o, ma_o, wb_o, rd_o, valid_o,
               stall_o, halt_o, illegal_o
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// Registered decode-stage controller.
// It decodes opcode/bit16/cond into the EX/MA/WB control bundles and holds
// them in the DE/EX control register. It also handles load-use stall,
// branch/jump flush, HLT freeze and illegal-opcode drop.
// Optional feature macro: DECODE_PERF_CNT_EN adds saturating stall and flush
// counters (stall_cnt_o, flush_cnt_o).
//
// ISA opcodes:
//   NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOT=6 SHL=7 LD=8 STX=9 BXX=10 JMP=11 HLT=12
//   Opcodes 13 and above are illegal.
//
// EX bundle fields:
//   [2:0] ALU_CTRL   [3] ALU_SRC2 (immediate)   [4] BRANCH   [5] JUMP   [6] LINK
//   [10:7] COND   [11] MEM_ADDR   [12] SHIFT   [13] HALT   [14] reserved (0)
// MA bundle fields:
//   [0] MA_EN   [1] MA_RW (1 = store)
// WB bundle fields:
//   [0] WB_R_WE   [2:1] WB_SRC (00 = ALU, 01 = memory, 10 = link PC)
//
// sign_ext_o modes:
//   00 = zero / none
//   01 = sign-extended data immediate (ADD/SUB/LD with bit16, STX)
//   10 = sign-extended branch offset (BXX)
module decode_ctrl_pipe #(
    parameter int OPCODE_W = 5,
    parameter int COND_W   = 4,
    parameter int REG_W    = 4,
    parameter int EX_W     = 15,
    parameter int MA_W     = 2,
    parameter int WB_W     = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    decode_ctrl_if.slave     bus
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_AND = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_OR  = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_XOR = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_NOT = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_SHL = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_LD  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_STX = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_BXX = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(12);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e state_q, state_d;

    // Decoded fields of the instruction currently in IF/DE.
    logic [2:0]        alu_ctrl;
    logic              alu_src2;
    logic              need_rs1;
    logic              need_rs2;
    logic              branch;
    logic              jump;
    logic              link;
    logic [COND_W-1:0] cond;
    logic              mem_addr;
    logic              shift;
    logic              hlt;
    logic              ma_en;
    logic              ma_rw;
    logic              wb_we;
    logic [1:0]        wb_src;
    logic              sel_rd;
    logic [1:0]        sext;
    logic              legal;

    logic [EX_W-1:0]   ex_dec;
    logic [MA_W-1:0]   ma_dec;
    logic [WB_W-1:0]   wb_dec;

    logic [EX_W-1:0]   ex_q;
    logic [MA_W-1:0]   ma_q;
    logic [WB_W-1:0]   wb_q;
    logic [REG_W-1:0]  rd_q;
    logic              valid_q;
    logic              illegal_q;

    logic [REG_W-1:0]  rs2_eff;
    logic              load_in_ex;
    logic              hazard;
    logic              load;
    logic              stall;
    logic              illegal_d;
    logic              flush_bubble;

    // Instruction decode table.
    // Every field not named by an opcode stays 0.
    always_comb begin
        // NOTE: every combinational output gets a default before the case,
        // so no path leaves a signal unassigned and no latch is inferred.
        alu_ctrl = 3'b000;
        alu_src2 = 1'b0;
        need_rs1 = 1'b0;
        need_rs2 = 1'b0;
        branch   = 1'b0;
        jump     = 1'b0;
        link     = 1'b0;
        cond     = '0;
        mem_addr = 1'b0;
        shift    = 1'b0;
        hlt      = 1'b0;
        ma_en    = 1'b0;
        ma_rw    = 1'b0;
        wb_we    = 1'b0;
        wb_src   = 2'b00;
        sel_rd   = 1'b0;
        sext     = 2'b00;
        legal    = 1'b1;
        case (bus.opcode_i)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                case (bus.opcode_i)
                    OP_ADD:  alu_ctrl = 3'b001;
                    OP_SUB:  alu_ctrl = 3'b010;
                    OP_AND:  alu_ctrl = 3'b011;
                    OP_OR:   alu_ctrl = 3'b100;
                    OP_XOR:  alu_ctrl = 3'b101;
                    default: alu_ctrl = 3'b111;
                endcase
                shift    = (bus.opcode_i == OP_SHL);
                need_rs1 = 1'b1;
                wb_we    = 1'b1;
                alu_src2 = bus.bit16_i;
                need_rs2 = !bus.bit16_i;
                // Only arithmetic immediates are signed; logic/shift immediates zero-extend.
                if (bus.bit16_i && (bus.opcode_i == OP_ADD || bus.opcode_i == OP_SUB))
                    sext = 2'b01;
            end
            OP_NOT: begin
                alu_ctrl = 3'b110;
                need_rs1 = 1'b1;
                wb_we    = 1'b1;
            end
            OP_LD: begin
                alu_ctrl = 3'b001;
                need_rs1 = 1'b1;
                alu_src2 = bus.bit16_i;
                need_rs2 = !bus.bit16_i;
                sext     = bus.bit16_i ? 2'b01 : 2'b00;
                mem_addr = 1'b1;
                ma_en    = 1'b1;
                wb_we    = 1'b1;
                wb_src   = 2'b01;
            end
            OP_STX: begin
                // Address is rs1 + imm. Store data is read through RF port 2 from rd.
                alu_ctrl = 3'b001;
                alu_src2 = 1'b1;
                need_rs1 = 1'b1;
                need_rs2 = 1'b1;
                sel_rd   = 1'b1;
                sext     = 2'b01;
                mem_addr = 1'b1;
                ma_en    = 1'b1;
                ma_rw    = 1'b1;
            end
            OP_BXX: begin
                branch   = 1'b1;
                cond     = bus.cond_i;
                alu_src2 = 1'b1;
                sext     = 2'b10;
            end
            OP_JMP: begin
                jump     = 1'b1;
                need_rs1 = 1'b1;
                link     = bus.bit16_i;
                wb_we    = bus.bit16_i;
                wb_src   = bus.bit16_i ? 2'b10 : 2'b00;
            end
            OP_HLT: hlt = 1'b1;
            default: legal = 1'b0;
        endcase
    end

    assign ex_dec = EX_W'({1'b0, hlt, shift, mem_addr, cond, link, jump, branch,
                           alu_src2, alu_ctrl});
    assign ma_dec = MA_W'({ma_rw, ma_en});
    assign wb_dec = WB_W'({wb_src, wb_we});

    // With no valid instruction present, the RF port-select and immediate mode are don't-cares, so they drive 0.
    assign bus.rs2_sel_o  = bus.valid_i & sel_rd;
    assign bus.sign_ext_o = bus.valid_i ? sext : 2'b00;

    // Load-use detection against the load currently held in DE/EX.
    assign rs2_eff    = bus.rs2_sel_o ? bus.rd_i : bus.rs2_i;
    assign load_in_ex = valid_q & ma_q[0] & !ma_q[1] & wb_q[0];
    assign hazard     = load_in_ex & bus.valid_i &
                        ((need_rs1 & (bus.rs1_i == rd_q)) |
                         (need_rs2 & (rs2_eff == rd_q)));

    // FSM next state and per-edge action.
    // Priority order: HALT, then flush, then hazard, then illegal, then accept.
    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        stall        = 1'b0;
        illegal_d    = 1'b0;
        flush_bubble = 1'b0;
        case (state_q)
            ST_HALT: stall = 1'b1;
            default: begin
                if (bus.flush_i) begin
                    flush_bubble = 1'b1;
                end else if (hazard) begin
                    stall = 1'b1;
                end else if (bus.valid_i && !legal) begin
                    illegal_d = 1'b1;
                end else if (bus.valid_i) begin
                    load = 1'b1;
                    if (bus.opcode_i == OP_HLT) state_d = ST_HALT;
                end
            end
        endcase
    end

    // FSM state register. HALT is left only through reset.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: reset is asynchronous, so it appears in the sensitivity list
        // and acts without waiting for a clock edge.
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // DE/EX control register. Anything other than an accepted instruction loads an all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_q      <= '0;
            ma_q      <= '0;
            wb_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= load ? ex_dec : '0;
            ma_q      <= load ? ma_dec : '0;
            wb_q      <= load ? wb_dec : '0;
            rd_q      <= load ? bus.rd_i : '0;
            valid_q   <= load;
            illegal_q <= illegal_d;
        end
    end

    assign bus.ex_o      = ex_q;
    assign bus.ma_o      = ma_q;
    assign bus.wb_o      = wb_q;
    assign bus.rd_o      = rd_q;
    assign bus.valid_o   = valid_q;
    assign bus.illegal_o = illegal_q;
    assign bus.stall_o   = stall;
    assign bus.halt_o    = (state_q == ST_HALT);

`ifdef DECODE_PERF_CNT_EN
    // Saturating count of load-use stall cycles taken while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt_o <= '0;
        else if (state_q == ST_RUN && stall && stall_cnt_o != '1)
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end

    // Saturating count of bubbles inserted because of flush_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flush_cnt_o <= '0;
        else if (flush_bubble && flush_cnt_o != '1)
            flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
`endif

endmodule
